// File: rtl/bypass_if.sv
// Operand-forwarding bus: retiring write, per-port read operands and bypass results.
interface bypass_if #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5,
  parameter int NPORTS  = 2
);
  logic                      hold;
  logic                      wb_valid;
  logic [REGBITS-1:0]        wb_regnum;
  logic [WIDTH-1:0]          wb_data;
  logic [NPORTS*REGBITS-1:0] rd_regnum;
  logic [NPORTS*WIDTH-1:0]   rd_data_in;
  logic [NPORTS*WIDTH-1:0]   rd_data_out;
  logic [NPORTS-1:0]         fwd_hit;
  logic [NPORTS*16-1:0]      hit_count;

  modport master (
    output hold, wb_valid, wb_regnum, wb_data, rd_regnum, rd_data_in,
    input  rd_data_out, fwd_hit, hit_count
  );

  modport slave (
    input  hold, wb_valid, wb_regnum, wb_data, rd_regnum, rd_data_in,
    output rd_data_out, fwd_hit, hit_count
  );
endinterface

// File: rtl/bypass_network.sv
// Register-operand forwarding: DEPTH-entry retired-write history plus optional live
// writeback forwarding, per-port newest-match selection and saturating hit counters.
module bypass_network #(
  parameter int WIDTH    = 32,
  parameter int REGBITS  = 5,
  parameter int DEPTH    = 2,
  parameter int NPORTS   = 2,
  parameter int LIVE_FWD = 1,
  parameter int ZERO_REG = 1
) (
  input  logic      clk,
  input  logic      reset,
  bypass_if.slave   bus
);

  logic               hist_vld  [DEPTH];
  logic [REGBITS-1:0] hist_reg  [DEPTH];
  logic [WIDTH-1:0]   hist_data [DEPTH];
  logic [15:0]        cnt       [NPORTS];

  logic [NPORTS*WIDTH-1:0] data_c;
  logic [NPORTS-1:0]       hit_c;
  logic [NPORTS*16-1:0]    cnt_flat;
  logic                    wb_rec;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    if (inc && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  function automatic logic is_zero_reg(input logic [REGBITS-1:0] r);
    return (ZERO_REG != 0) && (r == '0);
  endfunction

  assign wb_rec = bus.wb_valid & ~is_zero_reg(bus.wb_regnum);

  // History shift register and counters; frozen entirely while hold is high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_vld[i]  <= 1'b0;
        hist_reg[i]  <= '0;
        hist_data[i] <= '0;
      end
      for (int p = 0; p < NPORTS; p++) cnt[p] <= '0;
    end else if (!bus.hold) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        hist_vld[i]  <= hist_vld[i-1];
        hist_reg[i]  <= hist_reg[i-1];
        hist_data[i] <= hist_data[i-1];
      end
      hist_vld[0]  <= wb_rec;
      hist_reg[0]  <= bus.wb_regnum;
      hist_data[0] <= bus.wb_data;
      for (int p = 0; p < NPORTS; p++) cnt[p] <= sat_inc(cnt[p], hit_c[p]);
    end
  end

  // Scan oldest to youngest so later (younger) matches overwrite; live wb scanned last
  always_comb begin
    data_c = bus.rd_data_in;
    hit_c  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (!is_zero_reg(bus.rd_regnum[p*REGBITS +: REGBITS])) begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (hist_vld[i] && (hist_reg[i] == bus.rd_regnum[p*REGBITS +: REGBITS])) begin
            data_c[p*WIDTH +: WIDTH] = hist_data[i];
            hit_c[p]                 = 1'b1;
          end
        end
        if ((LIVE_FWD != 0) && bus.wb_valid &&
            (bus.wb_regnum == bus.rd_regnum[p*REGBITS +: REGBITS])) begin
          data_c[p*WIDTH +: WIDTH] = bus.wb_data;
          hit_c[p]                 = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int p = 0; p < NPORTS; p++) cnt_flat[p*16 +: 16] = cnt[p];
  end

  assign bus.rd_data_out = data_c;
  assign bus.fwd_hit     = hit_c;
  assign bus.hit_count   = cnt_flat;

endmodule

// File: tb/tb_bypass_network.sv
// Bench for bypass_network: constant vector table, directed corner sequences,
// and randomized traffic against a queue-based forwarding model.
module tb_bypass_network;
  localparam int W  = 32;
  localparam int RB = 5;
  localparam int D  = 2;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  bypass_if #(.WIDTH(W), .REGBITS(RB), .NPORTS(NP)) bus ();

  bypass_network #(.WIDTH(W), .REGBITS(RB), .DEPTH(D), .NPORTS(NP),
                   .LIVE_FWD(1), .ZERO_REG(1))
    dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Model: list of retired writes, youngest first, at most D kept
  typedef struct {
    bit          v;
    int          r;
    logic [31:0] d;
  } rec_t;
  rec_t hq[$];
  int   mcnt [NP];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_read(input int p, output logic [31:0] d, output bit h);
    int r;
    r = int'(bus.rd_regnum[p*RB +: RB]);
    d = bus.rd_data_in[p*W +: W];
    h = 0;
    if (r == 0) return;
    if (bus.wb_valid && int'(bus.wb_regnum) == r) begin
      d = bus.wb_data; h = 1; return;
    end
    foreach (hq[i]) begin
      if (hq[i].v && hq[i].r == r) begin
        d = hq[i].d; h = 1; return;
      end
    end
  endtask

  task automatic model_reset();
    hq.delete();
    for (int p = 0; p < NP; p++) mcnt[p] = 0;
  endtask

  task automatic cmp_model(input string tag);
    logic [31:0] d;
    bit h;
    for (int p = 0; p < NP; p++) begin
      model_read(p, d, h);
      chk($sformatf("%s_out%0d", tag, p), 64'(bus.rd_data_out[p*W +: W]), 64'(d));
      chk($sformatf("%s_hit%0d", tag, p), 64'(bus.fwd_hit[p]), 64'(h));
      chk($sformatf("%s_cnt%0d", tag, p), 64'(bus.hit_count[p*16 +: 16]), 64'(mcnt[p]));
    end
  endtask

  // Advance model using pre-edge inputs, then take the clock edge
  task automatic tick();
    logic [31:0] d;
    bit h;
    rec_t n;
    if (!bus.hold) begin
      for (int p = 0; p < NP; p++) begin
        model_read(p, d, h);
        if (h && mcnt[p] < 65535) mcnt[p]++;
      end
      n.v = bus.wb_valid && (bus.wb_regnum != 0);
      n.r = int'(bus.wb_regnum);
      n.d = bus.wb_data;
      hq.push_front(n);
      if (hq.size() > D) hq.pop_back();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    reset = 1'b0;
    #1;
  endtask

  task automatic set_in(input bit hold, input bit wv, input int wr, input logic [31:0] wd,
                        input int r0, input logic [31:0] i0, input int r1, input logic [31:0] i1);
    bus.hold      = hold;
    bus.wb_valid  = wv;
    bus.wb_regnum = RB'(wr);
    bus.wb_data   = wd;
    bus.rd_regnum = {RB'(r1), RB'(r0)};
    bus.rd_data_in = {i1, i0};
  endtask

  typedef struct {
    bit hold; bit wv; int wr; logic [31:0] wd;
    int r0; logic [31:0] i0; int r1; logic [31:0] i1;
    logic [31:0] e0; bit h0; logic [31:0] e1; bit h1;
    int c0; int c1;
  } vec_t;
  vec_t vt [7];

  initial begin
    vt[0] = '{0, 1, 3, 32'h30,   3, 32'hF0, 4, 32'hF1, 32'h30, 1, 32'hF1, 0, 0, 0};
    vt[1] = '{0, 1, 4, 32'h40,   3, 32'hF0, 4, 32'hF1, 32'h30, 1, 32'h40, 1, 1, 0};
    vt[2] = '{0, 0, 3, 32'h99,   3, 32'hF0, 4, 32'hF1, 32'h30, 1, 32'h40, 1, 2, 1};
    vt[3] = '{0, 0, 3, 32'h99,   3, 32'hF0, 4, 32'hF1, 32'hF0, 0, 32'h40, 1, 3, 2};
    vt[4] = '{0, 1, 0, 32'hDEAD, 0, 32'h0,  4, 32'hF1, 32'h0,  0, 32'hF1, 0, 3, 3};
    vt[5] = '{1, 1, 7, 32'h77,   7, 32'hF0, 0, 32'h5,  32'h77, 1, 32'h5,  0, 3, 3};
    vt[6] = '{0, 0, 0, 32'h0,    7, 32'hF0, 7, 32'hF1, 32'hF0, 0, 32'hF1, 0, 3, 3};

    reset = 1'b1;
    set_in(0, 0, 0, 0, 8, 32'h11, 0, 32'h22);
    #2;
    model_reset();
    chk("rst_out0", 64'(bus.rd_data_out[W-1:0]), 64'h11);
    chk("rst_hit", 64'(bus.fwd_hit), 64'h0);
    chk("rst_cnt", 64'(bus.hit_count), 64'h0);
    reset = 1'b0;
    #1;

    // Constant vector table
    foreach (vt[k]) begin
      set_in(vt[k].hold, vt[k].wv, vt[k].wr, vt[k].wd, vt[k].r0, vt[k].i0, vt[k].r1, vt[k].i1);
      #1;
      chk($sformatf("vec%0d_out0", k), 64'(bus.rd_data_out[0 +: W]), 64'(vt[k].e0));
      chk($sformatf("vec%0d_hit0", k), 64'(bus.fwd_hit[0]), 64'(vt[k].h0));
      chk($sformatf("vec%0d_out1", k), 64'(bus.rd_data_out[W +: W]), 64'(vt[k].e1));
      chk($sformatf("vec%0d_hit1", k), 64'(bus.fwd_hit[1]), 64'(vt[k].h1));
      chk($sformatf("vec%0d_cnt0", k), 64'(bus.hit_count[0 +: 16]), 64'(vt[k].c0));
      chk($sformatf("vec%0d_cnt1", k), 64'(bus.hit_count[16 +: 16]), 64'(vt[k].c1));
      tick();
    end

    // Youngest of two writes to the same register wins, then ages out
    do_reset();
    set_in(0, 1, 8, 32'hAAAA, 1, 0, 2, 0);
    tick();
    set_in(0, 1, 8, 32'hBBBB, 1, 0, 2, 0);
    tick();
    set_in(0, 0, 0, 0, 8, 32'h11, 2, 0);
    #1;
    chk("young_out", 64'(bus.rd_data_out[0 +: W]), 64'hBBBB);
    tick();
    chk("young_aged1", 64'(bus.rd_data_out[0 +: W]), 64'hBBBB);
    tick();
    chk("young_gone", 64'(bus.rd_data_out[0 +: W]), 64'h11);
    chk("young_gone_hit", 64'(bus.fwd_hit[0]), 64'h0);

    // Hold freezes history and counters; live wb still forwards
    do_reset();
    set_in(0, 1, 5, 32'h7, 5, 32'h0, 2, 0);
    tick();
    chk("hold_pre_cnt", 64'(bus.hit_count[0 +: 16]), 64'h1);
    set_in(1, 1, 5, 32'h9, 5, 32'h0, 2, 0);
    #1;
    chk("hold_live", 64'(bus.rd_data_out[0 +: W]), 64'h9);
    for (int k = 0; k < 3; k++) tick();
    chk("hold_cnt_frozen", 64'(bus.hit_count[0 +: 16]), 64'h1);
    set_in(1, 0, 5, 32'h9, 5, 32'h0, 2, 0);
    #1;
    chk("hold_keeps7", 64'(bus.rd_data_out[0 +: W]), 64'h7);
    tick();
    chk("hold_cnt_still", 64'(bus.hit_count[0 +: 16]), 64'h1);
    bus.hold = 1'b0;
    tick();
    chk("hold_cnt_inc", 64'(bus.hit_count[0 +: 16]), 64'h2);
    chk("hold_after_7", 64'(bus.rd_data_out[0 +: W]), 64'h7);

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(0, 4) == 0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
             $urandom_range(0, 7), $urandom, $urandom_range(0, 7), $urandom);
      #1;
      cmp_model($sformatf("rnd%0d", k));
      tick();
    end

    // Counter saturation then async reset between edges
    do_reset();
    set_in(0, 1, 1, 32'h5, 1, 32'h0, 2, 32'h0);
    for (int k = 0; k < 65534; k++) tick();
    chk("sat_fffe", 64'(bus.hit_count[0 +: 16]), 64'hFFFE);
    for (int k = 0; k < 3; k++) tick();
    chk("sat_ffff", 64'(bus.hit_count[0 +: 16]), 64'hFFFF);
    cmp_model("sat");
    set_in(0, 0, 0, 0, 1, 32'h33, 2, 32'h44);
    #1;
    chk("sat_hist_hit", 64'(bus.fwd_hit[0]), 64'h1);
    reset = 1'b1;
    #1;
    chk("async_cnt", 64'(bus.hit_count), 64'h0);
    chk("async_out", 64'(bus.rd_data_out[0 +: W]), 64'h33);
    chk("async_hit", 64'(bus.fwd_hit), 64'h0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
